// File: rtl/tone_seq_pkg.sv
// Shared constants for the tone sequencer: FSM state encodings and default
// half-period values for 1-4 kHz tones at a 12 MHz board clock.
package tone_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned HP_1KHZ = 6000;
    localparam int unsigned HP_2KHZ = 3000;
    localparam int unsigned HP_3KHZ = 2000;
    localparam int unsigned HP_4KHZ = 1500;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles out every h cycles; h == 0 means silence.
// clear forces the counter and output low for step boundaries and idle time.
module tone_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] h,
    output logic             out
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        out_d = out_q;
        if (clear || (h == '0)) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (cnt_q == h - DIV_W'(1)) begin
            cnt_d = '0;
            out_d = ~out_q;
        end
    end

    // NOTE: reset is synchronous (sampled on the clock edge) and state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/tone_seq.sv
// Multi-tone buzzer sequencer: plays NUM_TONES steps of STEP_TICKS cycles each.
// Define TONE_SEQ_GAP_EN to insert GAP_TICKS silent cycles after every step.
module tone_seq
    import tone_seq_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int NUM_TONES  = 4,
    parameter int DIV_W      = 16,
    parameter int STEP_W     = 24,
    parameter int STEP_TICKS = 12_000_000,
    parameter int GAP_TICKS  = 1_200_000,
    parameter int IDX_W      = $clog2(NUM_TONES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [NUM_TONES*DIV_W-1:0] half_per,
    output logic                       out,
    output logic                       busy,
    output logic [IDX_W-1:0]           step,
    output logic                       done
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TONES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
`ifdef TONE_SEQ_GAP_EN
    localparam logic [STEP_W-1:0] GAP_LAST  = STEP_W'(GAP_TICKS - 1);
`endif

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [STEP_W-1:0] dur_q, dur_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic              done_q, done_d;
    logic              advance;
    logic              step_end;
    logic              tone_clear;

    assign step_end = (state_q == ST_PLAY) && (dur_q == STEP_LAST);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dur_d   = dur_q;
        h_d     = h_q;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    step_d  = '0;
                    dur_d   = '0;
                    h_d     = half_per[0 +: DIV_W];
                end
            end
            ST_PLAY: begin
                if (step_end) begin
                    dur_d = '0;
`ifdef TONE_SEQ_GAP_EN
                    state_d = ST_GAP;
`else
                    advance = 1'b1;
`endif
                end else begin
                    dur_d = dur_q + STEP_W'(1);
                end
            end
`ifdef TONE_SEQ_GAP_EN
            ST_GAP: begin
                if (dur_q == GAP_LAST) begin
                    dur_d   = '0;
                    advance = 1'b1;
                end else begin
                    dur_d = dur_q + STEP_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // The table entry is sampled only here, so mid-step edits wait for the next entry.
        if (advance) begin
            if (step_q != LAST_IDX) begin
                state_d = ST_PLAY;
                step_d  = step_q + IDX_W'(1);
                h_d     = half_per[int'(step_q + IDX_W'(1)) * DIV_W +: DIV_W];
            end else if (loop) begin
                state_d = ST_PLAY;
                step_d  = '0;
                h_d     = half_per[0 +: DIV_W];
            end else begin
                state_d = ST_IDLE;
                step_d  = '0;
                done_d  = 1'b1;
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
            dur_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            dur_q   <= '0;
            h_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dur_q   <= dur_d;
            h_q     <= h_d;
            done_q  <= done_d;
        end
    end

    // Silence outside PLAY and on the last cycle of each step so out is 0 at every boundary.
    assign tone_clear = (state_q != ST_PLAY) || step_end || stop;

    tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tone_clear),
        .h    (h_q),
        .out  (out)
    );

    assign busy = (state_q != ST_IDLE);
    assign step = step_q;
    assign done = done_q;

endmodule
